// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory bus arbiter.
// Holds the FSM state and grant encodings used by the arbiter and its fetch buffer.
package mem_arbiter_pkg;

  localparam int unsigned TAG_W = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUS  = 2'd1,
    DBUS  = 2'd2,
    DRESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // The bus is word-addressed; byte offsets are carried by the write strobes.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_arbiter_fetch_buffer.sv
// One-entry instruction fetch buffer: fills on fetch ack, hit-compares against
// the current fetch address, and drops its entry when a store hits its word.
module fetch_buffer
  import mem_arbiter_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fill_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  input  logic [31:0]      fill_data_i,
  input  logic             inval_i,
  input  logic [TAG_W-1:0] inval_tag_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_o,
  output logic [31:0]      data_o
);

  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic             ok_q, ok_d;

  // Fill and store-invalidate come from different FSM states, so they never collide.
  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;
    ok_d   = ok_q;
    if (fill_i) begin
      tag_d  = fill_tag_i;
      data_d = fill_data_i;
      ok_d   = 1'b1;
    end else if (inval_i && (inval_tag_i == tag_q)) begin
      ok_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q  <= '0;
      data_q <= '0;
      ok_q   <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      data_q <= data_d;
      ok_q   <= ok_d;
    end
  end

  assign hit_o  = ok_q && (tag_q == lookup_tag_i);
  assign data_o = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one ack-handshaked memory bus between the CPU fetch and load/store ports,
// with data-first priority and alternating grants under contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr_i,
  output logic [31:0] o_data_i,
  output logic        o_valid_i,
  input  logic [31:0] i_addr_d,
  input  logic        i_rd_d,
  input  logic [3:0]  i_wr_d,
  input  logic [31:0] i_data_wr_d,
  output logic [31:0] o_data_rd_d,
  output logic        o_valid_d,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic [3:0]  o_mem_wr,
  output logic [31:0] o_mem_data_wr,
  input  logic [31:0] i_mem_data_rd,
  input  logic        i_mem_ack
);

  arb_state_e  state_q;
  grant_e      last_grant_q;
  logic [31:0] mem_addr_q;
  logic        mem_rd_q;
  logic [3:0]  mem_wr_q;
  logic [31:0] mem_data_wr_q;
  logic [31:0] data_rd_q;
  logic        valid_d_q;

  logic        dreq;
  logic        imiss;
  logic        fetch_hit;
  logic [31:0] fetch_data;
  logic        grant_valid;
  grant_e      grant_sel;
  logic        fill;
  logic        inval;

  assign dreq  = i_rd_d | (|i_wr_d);
  assign imiss = !fetch_hit;

  // Under contention the port that did not win last time goes next; DATA_PRIO
  // only decides the tie-break after an instruction grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = GNT_I;
    if (dreq && imiss) begin
      grant_valid = 1'b1;
      if (last_grant_q == GNT_D) begin
        grant_sel = GNT_I;
      end else begin
        grant_sel = DATA_PRIO ? GNT_D : GNT_I;
      end
    end else if (dreq) begin
      grant_valid = 1'b1;
      grant_sel   = GNT_D;
    end else if (imiss) begin
      grant_valid = 1'b1;
      grant_sel   = GNT_I;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      last_grant_q  <= GNT_I;
      mem_addr_q    <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= '0;
      mem_data_wr_q <= '0;
      data_rd_q     <= '0;
      valid_d_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_d_q <= 1'b0;
          if (grant_valid) begin
            last_grant_q <= grant_sel;
            if (grant_sel == GNT_D) begin
              // A request with any byte enable set is a store, even if rd is also high.
              mem_addr_q    <= word_align(i_addr_d);
              mem_rd_q      <= i_rd_d && (i_wr_d == 4'b0000);
              mem_wr_q      <= i_wr_d;
              mem_data_wr_q <= i_data_wr_d;
              state_q       <= DBUS;
            end else begin
              mem_addr_q <= word_align(i_addr_i);
              mem_rd_q   <= 1'b1;
              mem_wr_q   <= '0;
              state_q    <= IBUS;
            end
          end
        end
        IBUS: begin
          if (i_mem_ack) begin
            mem_rd_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        DBUS: begin
          if (i_mem_ack) begin
            if (mem_rd_q) begin
              data_rd_q <= i_mem_data_rd;
            end
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= '0;
            valid_d_q <= 1'b1;
            state_q   <= DRESP;
          end
        end
        DRESP: begin
          valid_d_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The buffer is tagged with the latched bus address, not the live fetch address.
  assign fill  = (state_q == IBUS) && i_mem_ack;
  assign inval = (state_q == DBUS) && i_mem_ack && (|mem_wr_q);

  fetch_buffer u_fetch_buffer (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .fill_i       (fill),
    .fill_tag_i   (mem_addr_q[31:2]),
    .fill_data_i  (i_mem_data_rd),
    .inval_i      (inval),
    .inval_tag_i  (mem_addr_q[31:2]),
    .lookup_tag_i (i_addr_i[31:2]),
    .hit_o        (fetch_hit),
    .data_o       (fetch_data)
  );

  assign o_valid_i     = fetch_hit;
  assign o_data_i      = fetch_data;
  assign o_data_rd_d   = data_rd_q;
  assign o_valid_d     = valid_d_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_rd      = mem_rd_q;
  assign o_mem_wr      = mem_wr_q;
  assign o_mem_data_wr = mem_data_wr_q;

endmodule
